avalon_st_width_downsizer: RTL and testbench

//  Parametrised wide-to-narrow Avalon-ST adapter: accepts one IN_WIDTH word, emits RATIO=IN_WIDTH/OUT_WIDTH
//  OUT_WIDTH beats in configurable lane order. Adds packet framing (sop/eop/empty-lane trimming) and

---
 rtl/avalon_st_pkg.sv | 12 +
 rtl/avalon_st_lane_mux.sv | 26 ++
 rtl/avalon_st_width_downsizer.sv | 110 +++++++++++
 tb/tb_avalon_st_width_downsizer.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/avalon_st_pkg.sv
// Shared Avalon-ST width adapter types and lane ordering helper.
// Lane 0 is the least-significant OUT_WIDTH slice of the wide word.
package avalon_st_pkg;

  typedef enum logic {IDLE, BUSY} dsz_state_t;

  // Maps emission position k onto the physical lane it comes from.
  function automatic int lane_index(input int k, input int ratio, input bit msb_first);
    return msb_first ? (ratio - 1 - k) : k;
  endfunction

endpackage

// File: rtl/avalon_st_lane_mux.sv
// Pure combinational lane select: picks the OUT_WIDTH slice that is emitted at position idx.
module avalon_st_lane_mux
  import avalon_st_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int IDX_W    = $clog2(RATIO) + 1
) (
  input  logic [IN_WIDTH-1:0]  data,
  input  logic [IDX_W-1:0]     idx,
  output logic [OUT_WIDTH-1:0] lane
);

  int sel;

  always_comb begin
    lane = '0;
    sel  = lane_index(int'(idx), RATIO, MSB_FIRST);
    for (int i = 0; i < RATIO; i++) begin
      if (sel == i) lane = data[i*OUT_WIDTH +: OUT_WIDTH];
    end
  end

endmodule

// File: rtl/avalon_st_width_downsizer.sv
// Wide-to-narrow Avalon-ST adapter: one IN_WIDTH word becomes up to RATIO beats, first beat the
// cycle after acceptance; the next word loads on the edge that consumes the last beat.
module avalon_st_width_downsizer
  import avalon_st_pkg::*;
#(
  parameter int IN_WIDTH  = 16,
  parameter int OUT_WIDTH = 8,
  parameter bit MSB_FIRST = 1'b1,
  localparam int RATIO    = IN_WIDTH / OUT_WIDTH,
  localparam int EMPTY_W  = $clog2(RATIO)
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic                 in_ready,
  input  logic                 in_valid,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic                 in_sop,
  input  logic                 in_eop,
  input  logic [EMPTY_W-1:0]   in_empty,
  input  logic                 out_ready,
  output logic                 out_valid,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_sop,
  output logic                 out_eop
);

  localparam int            CW      = EMPTY_W + 1;
  localparam logic [CW-1:0] RATIO_C = CW'(RATIO);

  dsz_state_t           state, state_nxt;
  logic [CW-1:0]        k, k_nxt, n, n_load, empty_ext;
  logic [IN_WIDTH-1:0]  hold_data;
  logic                 hold_sop, hold_eop;
  logic                 busy, last, load;
  logic [OUT_WIDTH-1:0] lane_dat;

  assign busy      = (state == BUSY);
  assign last      = busy && (k == n - CW'(1));
  assign empty_ext = CW'(in_empty);

  // Illegal empty counts collapse to a single beat rather than an empty word.
  always_comb begin
    n_load = RATIO_C;
    if (in_eop) begin
      n_load = (empty_ext >= RATIO_C) ? CW'(1) : (RATIO_C - empty_ext);
    end
  end

  assign in_ready  = !reset && (!busy || (last && out_ready));
  assign out_valid = busy;
  assign out_data  = busy ? lane_dat : '0;
  assign out_sop   = busy && hold_sop && (k == '0);
  assign out_eop   = last && hold_eop;

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    load      = 1'b0;
    case (state)
      IDLE: begin
        if (in_valid && in_ready) begin
          load      = 1'b1;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (!last)                      k_nxt     = k + CW'(1);
          else if (in_valid && in_ready)  load      = 1'b1;
          else                            state_nxt = IDLE;
        end
      end
    endcase
    if (load) k_nxt = '0;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      n         <= '0;
      hold_data <= '0;
      hold_sop  <= 1'b0;
      hold_eop  <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      if (load) begin
        hold_data <= in_data;
        hold_sop  <= in_sop;
        hold_eop  <= in_eop;
        n         <= n_load;
      end
    end
  end

  avalon_st_lane_mux #(
    .IN_WIDTH  (IN_WIDTH),
    .OUT_WIDTH (OUT_WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_lane_mux (
    .data (hold_data),
    .idx  (k),
    .lane (lane_dat)
  );

  a_empty_legal: assert property (@(posedge clock) disable iff (reset)
    (in_valid && in_ready && in_eop) |-> (empty_ext < RATIO_C));

endmodule

// File: tb/tb_avalon_st_width_downsizer.sv
// Directed vectors on three adapter configurations plus a randomized scoreboard run on the 16->8 one.
module tb_avalon_st_width_downsizer;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // a: 16->8 MSB first
  logic a_in_ready, a_in_valid, a_in_sop, a_in_eop, a_in_empty;
  logic [15:0] a_in_data;
  logic a_out_ready, a_out_valid, a_out_sop, a_out_eop;
  logic [7:0] a_out_data;
  // b: 32->8 LSB first
  logic b_in_ready, b_in_valid, b_in_sop, b_in_eop;
  logic [1:0] b_in_empty;
  logic [31:0] b_in_data;
  logic b_out_ready, b_out_valid, b_out_sop, b_out_eop;
  logic [7:0] b_out_data;
  // c: 32->8 MSB first
  logic c_in_ready, c_in_valid, c_in_sop, c_in_eop;
  logic [1:0] c_in_empty;
  logic [31:0] c_in_data;
  logic c_out_ready, c_out_valid, c_out_sop, c_out_eop;
  logic [7:0] c_out_data;

  avalon_st_width_downsizer #(.IN_WIDTH(16), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_a (
    .clock(clk), .reset(reset), .in_ready(a_in_ready), .in_valid(a_in_valid), .in_data(a_in_data),
    .in_sop(a_in_sop), .in_eop(a_in_eop), .in_empty(a_in_empty), .out_ready(a_out_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_sop(a_out_sop), .out_eop(a_out_eop));

  avalon_st_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b0)) dut_b (
    .clock(clk), .reset(reset), .in_ready(b_in_ready), .in_valid(b_in_valid), .in_data(b_in_data),
    .in_sop(b_in_sop), .in_eop(b_in_eop), .in_empty(b_in_empty), .out_ready(b_out_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_sop(b_out_sop), .out_eop(b_out_eop));

  avalon_st_width_downsizer #(.IN_WIDTH(32), .OUT_WIDTH(8), .MSB_FIRST(1'b1)) dut_c (
    .clock(clk), .reset(reset), .in_ready(c_in_ready), .in_valid(c_in_valid), .in_data(c_in_data),
    .in_sop(c_in_sop), .in_eop(c_in_eop), .in_empty(c_in_empty), .out_ready(c_out_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_sop(c_out_sop), .out_eop(c_out_eop));

  // Scoreboard for dut_a: expected beats as {data, sop, eop}.
  logic [9:0] exp_q[$];
  logic       sb_on = 1'b0;
  logic       acc_flag = 1'b0;
  int         acc_cnt = 0;
  int         beat_cnt = 0;

  always @(negedge clk) begin
    logic [9:0] e;
    int nb;
    if (sb_on) begin
      acc_flag = 1'b0;
      if (a_in_valid && a_in_ready) begin
        acc_flag = 1'b1;
        acc_cnt++;
        nb = (a_in_eop && a_in_empty) ? 1 : 2;
        for (int j = 0; j < nb; j++) begin
          e[9:2] = (j == 0) ? a_in_data[15:8] : a_in_data[7:0];
          e[1]   = a_in_sop && (j == 0);
          e[0]   = a_in_eop && (j == nb - 1);
          exp_q.push_back(e);
        end
      end
      if (a_out_valid && a_out_ready) begin
        beat_cnt++;
        if (exp_q.size() == 0) chk("sb_underflow", 32'd1, 32'd0);
        else begin
          e = exp_q.pop_front();
          chk("sb_beat", 32'({a_out_data, a_out_sop, a_out_eop}), 32'(e));
        end
      end
    end
  end

  initial begin
    logic [7:0] exp_b[4];
    logic [7:0] exp_c[6];
    int cyc;

    reset = 1'b1;
    a_in_valid = 0; a_in_data = '0; a_in_sop = 0; a_in_eop = 0; a_in_empty = 0; a_out_ready = 1;
    b_in_valid = 0; b_in_data = '0; b_in_sop = 0; b_in_eop = 0; b_in_empty = 0; b_out_ready = 1;
    c_in_valid = 0; c_in_data = '0; c_in_sop = 0; c_in_eop = 0; c_in_empty = 0; c_out_ready = 1;
    step(); step();
    @(negedge clk);
    chk("rst_in_ready", 32'(a_in_ready), 32'd0);
    chk("rst_out_valid", 32'({a_out_valid, b_out_valid, c_out_valid}), 32'd0);
    chk("rst_out_data", 32'(a_out_data), 32'd0);
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(a_in_ready), 32'd1);

    // 1: back-to-back words, zero bubble
    a_in_valid = 1; a_in_data = 16'hA1B2;
    step(); a_in_data = 16'hC3D4;
    @(negedge clk); chk("t1_b0", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hA1, 1'b0}));
    step();
    @(negedge clk); chk("t1_b1", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hB2, 1'b1}));
    step(); a_in_valid = 0;
    @(negedge clk); chk("t1_b2", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hC3, 1'b0}));
    step();
    @(negedge clk); chk("t1_b3", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hD4, 1'b1}));
    step();
    @(negedge clk); chk("t1_idle", 32'({a_out_valid, a_out_data}), 32'd0);

    // 3: backpressure on 16'hBEEF
    a_in_valid = 1; a_in_data = 16'hBEEF; a_out_ready = 0;
    step(); a_in_valid = 0;
    @(negedge clk); chk("t3_stall0", 32'({a_out_valid, a_out_data}), 32'({1'b1, 8'hBE}));
    step();
    @(negedge clk); chk("t3_stall1", 32'({a_out_valid, a_out_data}), 32'({1'b1, 8'hBE}));
    step(); a_out_ready = 1;
    @(negedge clk); chk("t3_take_be", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hBE, 1'b0}));
    step(); a_out_ready = 0;
    @(negedge clk); chk("t3_hold_ef", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hEF, 1'b0}));
    step(); a_out_ready = 1;
    @(negedge clk); chk("t3_take_ef", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'hEF, 1'b1}));
    step();
    @(negedge clk); chk("t3_idle", 32'(a_out_valid), 32'd0);

    // 5: reset while busy after first beat
    a_in_valid = 1; a_in_data = 16'h1234;
    step(); a_in_valid = 0; reset = 1;
    @(negedge clk); chk("t5_b0", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b1, 8'h12, 1'b0}));
    step(); reset = 0; a_in_valid = 1; a_in_data = 16'h5678;
    @(negedge clk); chk("t5_flushed", 32'({a_out_valid, a_out_data, a_in_ready}), 32'({1'b0, 8'h00, 1'b1}));
    step(); a_in_valid = 0;
    @(negedge clk); chk("t5_56", 32'({a_out_valid, a_out_data}), 32'({1'b1, 8'h56}));
    step();
    @(negedge clk); chk("t5_78", 32'({a_out_valid, a_out_data}), 32'({1'b1, 8'h78}));
    step();
    @(negedge clk); chk("t5_idle", 32'(a_out_valid), 32'd0);

    // 2: 32->8 LSB first
    exp_b = '{8'h44, 8'h33, 8'h22, 8'h11};
    b_in_valid = 1; b_in_data = 32'h11223344;
    step(); b_in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk($sformatf("t2_b%0d", i), 32'({b_out_valid, b_out_data}), 32'({1'b1, exp_b[i]}));
      step();
    end
    @(negedge clk); chk("t2_idle", 32'(b_out_valid), 32'd0);

    // 4: two-word packet, eop word with two empty lanes
    exp_c = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
    c_in_valid = 1; c_in_data = 32'h01020304; c_in_sop = 1;
    step(); c_in_data = 32'h05060000; c_in_sop = 0; c_in_eop = 1; c_in_empty = 2'd2;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk($sformatf("t4_b%0d", i), 32'({c_out_valid, c_out_data, c_out_sop, c_out_eop, c_in_ready}),
          32'({1'b1, exp_c[i], i == 0, i == 5, (i == 3) || (i == 5)}));
      step();
      if (i == 3) c_in_valid = 0;
    end
    @(negedge clk); chk("t4_idle", 32'(c_out_valid), 32'd0);

    // 6: throughput then random traffic against the scoreboard
    sb_on = 1; beat_cnt = 0;
    a_in_valid = 1; a_in_data = 16'h0001; a_in_sop = 0; a_in_eop = 0; a_in_empty = 0; a_out_ready = 1;
    for (int c = 0; c < 100; c++) begin
      step();
      if (acc_flag) a_in_data = a_in_data + 16'h0101;
    end
    chk("t6_throughput", 32'(beat_cnt), 32'd99);

    cyc = 0;
    while (acc_cnt < 10000 && cyc < 60000) begin
      if (!a_in_valid || acc_flag) begin
        a_in_valid = ($urandom % 4) != 0;
        a_in_data  = 16'($urandom);
        a_in_sop   = 1'($urandom);
        a_in_eop   = 1'($urandom);
        a_in_empty = 1'($urandom);
      end
      a_out_ready = ($urandom % 4) != 0;
      step();
      cyc++;
    end
    a_in_valid = 0; a_out_ready = 1;
    chk("t6_words_done", 32'(acc_cnt >= 10000), 32'd1);
    for (int c = 0; c < 20 && exp_q.size() > 0; c++) step();
    step();
    chk("t6_drained", 32'(exp_q.size()), 32'd0);
    sb_on = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
